// File: rtl/cpu_bus_pkg.sv
//------------------------------------------------------------------------------
// cpu_bus_pkg
//   Source ids and access-size encodings shared by the CPU memory-port logic.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_bus_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

endpackage

`default_nettype wire

// File: rtl/id_fifo.sv
//------------------------------------------------------------------------------
// id_fifo
//   1-bit order FIFO of outstanding request sources, bypass when empty.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic pop_ok,
    output logic full,
    output logic empty
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_max = c_ptr_w'(DEPTH - 1);

    logic [DEPTH-1:0]   mem_q, mem_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    logic w_bypass;
    logic w_do_push;
    logic w_do_pop;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == c_depth);
    // An empty FIFO answers with the id being pushed in the same cycle.
    assign head   = empty ? push_id : mem_q[rd_ptr_q];
    assign pop_ok = pop && (!empty || push);

    assign w_bypass  = empty && push && pop;
    assign w_do_push = push && !w_bypass && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = (wr_ptr_q == c_ptr_max) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = (rd_ptr_q == c_ptr_max) ? '0 : rd_ptr_q + 1'b1;
        end
        if (w_do_push && !w_do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one split-handshake memory port between inst fetch and load/store.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int OUTST      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [DATA_W/8-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                mem_req,
    output logic                mem_wr,
    output logic [1:0]          mem_size,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int c_starve_w = $clog2(STARVE_LIM + 1);
    localparam logic [c_starve_w-1:0] c_starve_lim = c_starve_w'(STARVE_LIM);

    logic                  lock_valid_q, lock_valid_d;
    logic                  lock_id_q, lock_id_d;
    logic [c_starve_w-1:0] starve_q, starve_d;

    logic w_starved;
    logic w_sel_id;
    logic w_sel_req;
    logic w_block;
    logic w_xfer;
    logic w_pop;
    logic w_pop_ok;
    logic w_head;
    logic w_fifo_full;
    logic w_fifo_empty;

    // Data wins unless inst has waited through STARVE_LIM data grants.
    assign w_starved = (starve_q == c_starve_lim) && inst_req;
    assign w_sel_id  = lock_valid_q ? lock_id_q
                     : ((data_req && !w_starved) ? SRC_DATA : SRC_INST);
    assign w_sel_req = (w_sel_id == SRC_DATA) ? data_req : inst_req;

    // A full FIFO can only take a new request when a response frees a slot.
    assign w_block = w_fifo_full && !mem_data_ok;
    assign mem_req = w_sel_req && !w_block && !reset;
    assign w_xfer  = mem_req && mem_addr_ok;
    assign w_pop   = mem_data_ok && !reset;

    assign inst_addr_ok = w_xfer && (w_sel_id == SRC_INST);
    assign data_addr_ok = w_xfer && (w_sel_id == SRC_DATA);
    assign inst_data_ok = w_pop_ok && (w_head == SRC_INST);
    assign data_data_ok = w_pop_ok && (w_head == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (w_sel_id == SRC_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_wstrb = inst_wstrb;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;
        if (mem_req && !mem_addr_ok) begin
            lock_valid_d = 1'b1;
            lock_id_d    = w_sel_id;
        end else if (w_xfer) begin
            lock_valid_d = 1'b0;
        end else if (lock_valid_q && !w_sel_req) begin
            lock_valid_d = 1'b0;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!inst_req || inst_addr_ok) begin
            starve_d = '0;
        end else if (data_addr_ok && (starve_q != c_starve_lim)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= SRC_INST;
            starve_q     <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            starve_q     <= starve_d;
        end
    end

    id_fifo #(
        .DEPTH (OUTST)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_xfer),
        .push_id (w_sel_id),
        .pop     (w_pop),
        .head    (w_head),
        .pop_ok  (w_pop_ok),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    logic w_unused;
    assign w_unused = w_fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, mem_size;
    logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
    logic [31:0] inst_addr, data_addr, mem_addr;
    logic [31:0] inst_wdata, data_wdata, mem_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata, mem_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .OUTST(2), .STARVE_LIM(4)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hF;
        data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        tick();
        inst_req = 1; inst_addr = 32'h1234_5678; mem_addr_ok = 1; mem_data_ok = 1;
        #2;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        checks++;
        if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL rst_addr_ok: got %b expected 0", inst_addr_ok); end
        checks++;
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL rst_data_ok: got %b expected 00", {inst_data_ok, data_data_ok}); end
        checks++;
        tick();
        reset = 0; idle();
        #2;
        if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
            errors++; $display("FAIL post_rst_outputs: got %b expected 00000",
                {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        checks++;
    endtask

    task automatic test_single_inst();
        tick();
        inst_req = 1; inst_addr = 32'h1C00_0000;
        #2;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0000) begin
            errors++; $display("FAIL si_req: got req=%b addr=%h expected 1 1c000000", mem_req, mem_addr);
        end
        checks++;
        if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL si_wait0: got %b expected 0", inst_addr_ok); end
        checks++;
        tick();
        #2;
        if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL si_wait1: got %b expected 0", inst_addr_ok); end
        checks++;
        tick();
        mem_addr_ok = 1;
        #2;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            errors++; $display("FAIL si_accept: got %b expected 10", {inst_addr_ok, data_addr_ok});
        end
        checks++;
        for (int i = 0; i < 2; i++) begin
            tick();
            inst_req = 0; mem_addr_ok = 0;
            #2;
            if ({inst_addr_ok, inst_data_ok, data_data_ok} !== 3'b000) begin
                errors++; $display("FAIL si_quiet%0d: got %b expected 000", i, {inst_addr_ok, inst_data_ok, data_data_ok});
            end
            checks++;
        end
        tick();
        mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
        #2;
        if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h0280_0C0C) begin
            errors++; $display("FAIL si_resp: got ok=%b rdata=%h expected 10 02800c0c",
                {inst_data_ok, data_data_ok}, inst_rdata);
        end
        checks++;
        tick();
        idle();
        #2;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++; $display("FAIL si_after: got %b expected 00", {inst_data_ok, data_data_ok});
        end
        checks++;
    endtask

    task automatic test_both();
        tick();
        inst_req = 1; inst_addr = 32'h1C00_0004;
        data_req = 1; data_wr = 1; data_addr = 32'h8000_0010;
        mem_addr_ok = 1;
        #2;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01 || mem_addr !== 32'h8000_0010 || mem_wr !== 1'b1) begin
            errors++; $display("FAIL both_first: got ok=%b addr=%h wr=%b expected 01 80000010 1",
                {inst_addr_ok, data_addr_ok}, mem_addr, mem_wr);
        end
        checks++;
        tick();
        data_req = 0;
        #2;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10 || mem_addr !== 32'h1C00_0004) begin
            errors++; $display("FAIL both_second: got ok=%b addr=%h expected 10 1c000004",
                {inst_addr_ok, data_addr_ok}, mem_addr);
        end
        checks++;
        tick();
        idle();
        mem_data_ok = 1; mem_rdata = 32'hDEAD_0001;
        #2;
        if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'hDEAD_0001) begin
            errors++; $display("FAIL both_resp1: got ok=%b rdata=%h expected 01 dead0001",
                {inst_data_ok, data_data_ok}, data_rdata);
        end
        checks++;
        tick();
        mem_rdata = 32'hDEAD_0002;
        #2;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            errors++; $display("FAIL both_resp2: got %b expected 10", {inst_data_ok, data_data_ok});
        end
        checks++;
        tick();
        idle();
    endtask

    task automatic test_lock();
        // data first, inst arrives while data waits
        data_req = 1; data_wr = 1; data_addr = 32'h0000_00A0;
        #2;
        if (mem_addr !== 32'hA0 || mem_wr !== 1'b1) begin
            errors++; $display("FAIL lock_d0: got addr=%h wr=%b expected a0 1", mem_addr, mem_wr);
        end
        checks++;
        for (int i = 1; i < 3; i++) begin
            tick();
            inst_req = 1; inst_addr = 32'h0000_00B0;
            #2;
            if (mem_addr !== 32'hA0 || mem_wr !== 1'b1 || inst_addr_ok !== 1'b0) begin
                errors++; $display("FAIL lock_d%0d: got addr=%h wr=%b iok=%b expected a0 1 0",
                    i, mem_addr, mem_wr, inst_addr_ok);
            end
            checks++;
        end
        tick();
        mem_addr_ok = 1;
        #2;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
            errors++; $display("FAIL lock_d_accept: got %b expected 01", {inst_addr_ok, data_addr_ok});
        end
        checks++;
        tick();
        data_req = 0;
        #2;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10 || mem_addr !== 32'hB0 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL lock_d_then_i: got ok=%b addr=%h wr=%b expected 10 b0 0",
                {inst_addr_ok, data_addr_ok}, mem_addr, mem_wr);
        end
        checks++;
        tick();
        idle(); mem_data_ok = 1;
        #2;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            errors++; $display("FAIL lock_d_resp1: got %b expected 01", {inst_data_ok, data_data_ok});
        end
        checks++;
        tick();
        #2;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            errors++; $display("FAIL lock_d_resp2: got %b expected 10", {inst_data_ok, data_data_ok});
        end
        checks++;
        // inst first, data arrives while inst waits: lock must keep inst
        tick();
        idle();
        inst_req = 1; inst_addr = 32'h0000_00C0;
        #2;
        if (mem_addr !== 32'hC0) begin errors++; $display("FAIL lock_i0: got %h expected c0", mem_addr); end
        checks++;
        tick();
        data_req = 1; data_addr = 32'h0000_00D0;
        #2;
        if (mem_addr !== 32'hC0 || data_addr_ok !== 1'b0) begin
            errors++; $display("FAIL lock_i1: got addr=%h dok=%b expected c0 0", mem_addr, data_addr_ok);
        end
        checks++;
        tick();
        mem_addr_ok = 1;
        #2;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            errors++; $display("FAIL lock_i_accept: got %b expected 10", {inst_addr_ok, data_addr_ok});
        end
        checks++;
        tick();
        inst_req = 0;
        #2;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01 || mem_addr !== 32'hD0) begin
            errors++; $display("FAIL lock_i_then_d: got ok=%b addr=%h expected 01 d0",
                {inst_addr_ok, data_addr_ok}, mem_addr);
        end
        checks++;
        tick();
        idle(); mem_data_ok = 1;
        #2;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            errors++; $display("FAIL lock_i_resp1: got %b expected 10", {inst_data_ok, data_data_ok});
        end
        checks++;
        tick();
        #2;
        if ({inst_data_ok, data_data_ok} !== 2'b01) begin
            errors++; $display("FAIL lock_i_resp2: got %b expected 01", {inst_data_ok, data_data_ok});
        end
        checks++;
        tick();
        idle();
    endtask

    task automatic test_starve();
        logic [9:0] exp_inst;
        exp_inst = 10'b10_0001_0000;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        for (int i = 0; i < 10; i++) begin
            #2;
            if ({inst_addr_ok, data_addr_ok} !== {exp_inst[i], ~exp_inst[i]}) begin
                errors++; $display("FAIL starve_grant%0d: got %b expected %b",
                    i, {inst_addr_ok, data_addr_ok}, {exp_inst[i], ~exp_inst[i]});
            end
            checks++;
            if ({inst_data_ok, data_data_ok} !== {exp_inst[i], ~exp_inst[i]}) begin
                errors++; $display("FAIL starve_route%0d: got %b expected %b",
                    i, {inst_data_ok, data_data_ok}, {exp_inst[i], ~exp_inst[i]});
            end
            checks++;
            tick();
        end
        idle();
    endtask

    task automatic test_full_and_reset();
        data_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got %b expected 1", i, data_addr_ok); end
            checks++;
            tick();
        end
        #2;
        if (mem_req !== 1'b0 || data_addr_ok !== 1'b0) begin
            errors++; $display("FAIL full_block: got req=%b ok=%b expected 0 0", mem_req, data_addr_ok);
        end
        checks++;
        tick();
        mem_data_ok = 1;
        #2;
        if ({mem_req, data_addr_ok, data_data_ok} !== 3'b111) begin
            errors++; $display("FAIL full_pushpop: got %b expected 111", {mem_req, data_addr_ok, data_data_ok});
        end
        checks++;
        tick();
        mem_data_ok = 0;
        #2;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL full_again: got %b expected 0", mem_req); end
        checks++;
        // reset with two outstanding
        tick();
        reset = 1;
        #2;
        if (mem_req !== 1'b0 || data_addr_ok !== 1'b0) begin
            errors++; $display("FAIL midrst_req: got req=%b ok=%b expected 0 0", mem_req, data_addr_ok);
        end
        checks++;
        tick();
        reset = 0; idle(); mem_data_ok = 1;
        #2;
        if ({mem_req, inst_data_ok, data_data_ok} !== 3'b000) begin
            errors++; $display("FAIL midrst_spurious: got %b expected 000", {mem_req, inst_data_ok, data_data_ok});
        end
        checks++;
        tick();
        mem_data_ok = 0; data_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL midrst_fill%0d: got %b expected 1", i, data_addr_ok); end
            checks++;
            tick();
        end
        #2;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b expected 0", mem_req); end
        checks++;
        tick();
        idle(); mem_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            if ({inst_data_ok, data_data_ok} !== 2'b01) begin
                errors++; $display("FAIL midrst_drain%0d: got %b expected 01", i, {inst_data_ok, data_data_ok});
            end
            checks++;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_inst();
        test_both();
        test_lock();
        test_starve();
        test_full_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
